// File: rtl/ti_serial_share_loader.sv
// ti_serial_share_loader: shifts SHARES key/plaintext share streams in from a narrow bus,
// presents them as parallel share vectors and sequences one start pulse per go.
`default_nettype none

module ti_serial_share_loader #(
  parameter int SHARES = 2,
  parameter int BLK_W  = 128,
  parameter int KEY_W  = 128,
  parameter int BUS_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SHARES*BUS_W-1:0]  data_in,
  input  logic [1:0]               data_rdy,
  input  logic                     core_done,
  output logic [SHARES*KEY_W-1:0]  key_sh,
  output logic [SHARES*BLK_W-1:0]  pt_sh,
  output logic                     key_valid,
  output logic                     pt_valid,
  output logic                     start,
  output logic                     trig,
  output logic                     err
);

  localparam int KEY_BEATS = KEY_W / BUS_W;
  localparam int PT_BEATS  = BLK_W / BUS_W;
  localparam int KCW       = $clog2(KEY_BEATS + 1);
  localparam int PCW       = $clog2(PT_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic [SHARES*KEY_W-1:0]   key_q, key_d;
  logic [SHARES*BLK_W-1:0]   pt_q, pt_d;
  logic [KCW-1:0]            key_cnt_q, key_cnt_d;
  logic [PCW-1:0]            pt_cnt_q, pt_cnt_d;
  logic                      key_vld_q, key_vld_d;
  logic                      pt_vld_q, pt_vld_d;
  logic [1:0]                rdy_prev_q;
  logic                      start_q, start_d;
  logic                      trig_q, trig_d;
  logic                      err_q, err_d;

  logic key_beat, pt_beat, go, load_ok;
  int   kidx, pidx;

  assign key_beat = (data_rdy == 2'b10);
  assign pt_beat  = (data_rdy == 2'b01);
  assign go       = (data_rdy == 2'b11) && (rdy_prev_q != 2'b11);
  assign load_ok  = (state_q != S_RUN);

  // A beat arriving while the field is already valid restarts it at index 0;
  // the remaining upper bits are deliberately left untouched.
  always_comb begin
    key_d     = key_q;
    key_cnt_d = key_cnt_q;
    key_vld_d = key_vld_q;
    kidx      = key_vld_q ? 0 : int'(key_cnt_q);
    if (key_beat && load_ok) begin
      for (int s = 0; s < SHARES; s++)
        key_d[s*KEY_W + kidx*BUS_W +: BUS_W] = data_in[s*BUS_W +: BUS_W];
      if (key_vld_q) begin
        key_vld_d = 1'b0;
        key_cnt_d = KCW'(1);
      end else if (key_cnt_q == KCW'(KEY_BEATS - 1)) begin
        key_vld_d = 1'b1;
        key_cnt_d = '0;
      end else begin
        key_cnt_d = key_cnt_q + KCW'(1);
      end
    end
  end

  always_comb begin
    pt_d     = pt_q;
    pt_cnt_d = pt_cnt_q;
    pt_vld_d = pt_vld_q;
    pidx     = pt_vld_q ? 0 : int'(pt_cnt_q);
    if (pt_beat && load_ok) begin
      for (int s = 0; s < SHARES; s++)
        pt_d[s*BLK_W + pidx*BUS_W +: BUS_W] = data_in[s*BUS_W +: BUS_W];
      if (pt_vld_q) begin
        pt_vld_d = 1'b0;
        pt_cnt_d = PCW'(1);
      end else if (pt_cnt_q == PCW'(PT_BEATS - 1)) begin
        pt_vld_d = 1'b1;
        pt_cnt_d = '0;
      end else begin
        pt_cnt_d = pt_cnt_q + PCW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    trig_d  = trig_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (go) err_d = 1'b1;
        if (key_vld_q && pt_vld_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!(key_vld_d && pt_vld_d)) begin
          state_d = S_IDLE;
        end else if (go) begin
          start_d = 1'b1;
          trig_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (key_beat || pt_beat) err_d = 1'b1;
        if (core_done) begin
          trig_d  = 1'b0;
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      pt_q       <= '0;
      key_cnt_q  <= '0;
      pt_cnt_q   <= '0;
      key_vld_q  <= 1'b0;
      pt_vld_q   <= 1'b0;
      rdy_prev_q <= 2'b00;
      start_q    <= 1'b0;
      trig_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      key_cnt_q  <= key_cnt_d;
      pt_cnt_q   <= pt_cnt_d;
      key_vld_q  <= key_vld_d;
      pt_vld_q   <= pt_vld_d;
      rdy_prev_q <= data_rdy;
      start_q    <= start_d;
      trig_q     <= trig_d;
      err_q      <= err_d;
    end
  end

  assign key_sh    = key_q;
  assign pt_sh     = pt_q;
  assign key_valid = key_vld_q;
  assign pt_valid  = pt_vld_q;
  assign start     = start_q;
  assign trig      = trig_q;
  assign err       = err_q;

endmodule

`default_nettype wire
